ip2_scan_out_capture: RTL and testbench

- Readout counterpart of the IP2 scan-chain shift-in sequencer. Drives the ASIC scan_load, parallel-loads the pixel comparator results into the scan chain, then serially captures scan_out, one bit per slow ASIC scan period.
- Packs the captured bits LSB-first into 32-bit words and presents them on a valid/ready port toward the readout FIFO / AXI register bank.
- Timed by the shared 400 MHz FM clock and the shared clk_counter phase counter.

---
 rtl/ip2_scan_out_capture_if.sv | 26 ++
 rtl/ip2_scan_out_capture.sv | 169 ++++++++++++++++
 tb/tb_ip2_scan_out_capture.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ip2_scan_out_capture_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ip2_scan_out_capture_if                                          |
// | Valid/ready word port from the scan capture toward readout FIFO. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface ip2_scan_out_capture_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface
`default_nettype wire

// File: rtl/ip2_scan_out_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ip2_scan_out_capture                                             |
// | Loads comparator results into the ASIC scan chain, then captures |
// | scan_out serially and packs it LSB-first into words.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ip2_scan_out_capture #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [5:0]             clk_counter,
  input  logic [5:0]             test_delay,
  input  logic [5:0]             test_sample_phase,
  input  logic                   start_re,
  input  logic [CNT_W-1:0]       scan_cnt_max,
  input  logic                   scan_out,
  ip2_scan_out_capture_if.master word_if,
  output logic                   o_scan_load,
  output logic [CNT_W-1:0]       bit_cnt,
  output logic                   status_done,
  output logic                   status_overflow,
  output logic [2:0]             state
);
  localparam int SLOT_W = $clog2(WORD_W);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(WORD_W - 1);

  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_DELAY = 3'd1;
  localparam logic [2:0] C_ST_LOAD  = 3'd2;
  localparam logic [2:0] C_ST_SHIFT = 3'd3;
  localparam logic [2:0] C_ST_FLUSH = 3'd4;
  localparam logic [2:0] C_ST_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic              r_scan_load;
  logic [WORD_W-1:0] r_acc;
  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_word_data;
  logic              r_word_valid;
  logic              r_done;
  logic              r_overflow;

  logic              w_tick;
  logic              w_sample;
  logic              w_last_bit;
  logic              w_push;
  logic              w_can_load;
  logic [CNT_W-1:0]  w_bit_cnt_inc;
  logic [WORD_W-1:0] w_acc_next;
  logic [WORD_W-1:0] w_push_word;

  assign w_tick        = (clk_counter == test_delay);
  assign w_sample      = (r_state == C_ST_SHIFT) && (clk_counter == test_sample_phase);
  assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
  assign w_last_bit    = (w_bit_cnt_inc >= scan_cnt_max);
  assign w_can_load    = !r_word_valid || word_if.word_ready;

  always_comb begin
    w_acc_next         = r_acc;
    w_acc_next[r_slot] = scan_out;
  end

  // Full words leave straight from the sampling edge; FLUSH only emits a partial word.
  assign w_push      = (w_sample && (r_slot == C_SLOT_LAST)) ||
                       ((r_state == C_ST_FLUSH) && (r_slot != '0));
  assign w_push_word = (r_state == C_ST_FLUSH) ? r_acc : w_acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= C_ST_IDLE;
      r_scan_load  <= 1'b1;
      r_acc        <= '0;
      r_slot       <= '0;
      r_bit_cnt    <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (!enable) begin
      r_state      <= C_ST_IDLE;
      r_scan_load  <= 1'b1;
      r_acc        <= '0;
      r_slot       <= '0;
      r_bit_cnt    <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        if (w_can_load) begin
          r_word_data  <= w_push_word;
          r_word_valid <= 1'b1;
        end else begin
          r_overflow   <= 1'b1;
        end
      end else if (word_if.word_ready) begin
        r_word_valid <= 1'b0;
      end

      case (r_state)
        C_ST_IDLE: begin
          r_scan_load <= 1'b1;
          if (start_re) begin
            r_state    <= C_ST_DELAY;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        C_ST_DELAY: begin
          if (w_tick) r_state <= C_ST_LOAD;
        end
        C_ST_LOAD: begin
          if (w_tick) begin
            if (scan_cnt_max == '0) begin
              r_state <= C_ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= C_ST_SHIFT;
              r_scan_load <= 1'b0;
              r_acc       <= '0;
              r_slot      <= '0;
            end
          end
        end
        C_ST_SHIFT: begin
          if (w_sample) begin
            r_acc  <= (r_slot == C_SLOT_LAST) ? '0 : w_acc_next;
            r_slot <= r_slot + 1'b1;
            if (r_bit_cnt != scan_cnt_max) r_bit_cnt <= w_bit_cnt_inc;
            if (w_last_bit) begin
              r_state     <= C_ST_FLUSH;
              r_scan_load <= 1'b1;
            end
          end
        end
        C_ST_FLUSH: begin
          r_state <= C_ST_DONE;
          r_done  <= 1'b1;
          r_acc   <= '0;
          r_slot  <= '0;
        end
        C_ST_DONE: begin
          r_scan_load <= 1'b1;
          r_state     <= C_ST_IDLE;
        end
        default: begin
          r_state     <= C_ST_IDLE;
          r_scan_load <= 1'b1;
        end
      endcase
    end
  end

  assign o_scan_load        = r_scan_load;
  assign bit_cnt            = r_bit_cnt;
  assign status_done        = r_done;
  assign status_overflow    = r_overflow;
  assign state              = r_state;
  assign word_if.word_data  = r_word_data;
  assign word_if.word_valid = r_word_valid;
endmodule
`default_nettype wire

// File: tb/tb_ip2_scan_out_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ip2_scan_out_capture                                          |
// | Vector table of capture runs with a word scoreboard.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ip2_scan_out_capture;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 11;
  localparam int PERIOD = 8;

  typedef struct {
    string       name;
    int          max;
    int          mode;
    bit          ready;
    int          off;
    int          words;
    logic [31:0] w0;
    logic [31:0] wlast;
    bit          ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, enable, start_re, scan_out;
  logic [5:0]       clk_counter, test_delay, test_sample_phase;
  logic [CNT_W-1:0] scan_cnt_max, bit_cnt;
  logic             o_scan_load, status_done, status_overflow;
  logic [2:0]       state;

  ip2_scan_out_capture_if #(.WORD_W(WORD_W)) word_if ();

  ip2_scan_out_capture #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .clk_counter       (clk_counter),
    .test_delay        (test_delay),
    .test_sample_phase (test_sample_phase),
    .start_re          (start_re),
    .scan_cnt_max      (scan_cnt_max),
    .scan_out          (scan_out),
    .word_if           (word_if),
    .o_scan_load       (o_scan_load),
    .bit_cnt           (bit_cnt),
    .status_done       (status_done),
    .status_overflow   (status_overflow),
    .state             (state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_bad = 0;
  int          pat_mode = 0, run_max = 0, samp_idx = 0, ticks = 0;
  bit          run_armed = 0, shift_phase = 0;
  logic [31:0] exp_acc;
  logic [31:0] sb_q[$];
  int          n_pop, n_extra, valid_seen, load_viol, stab_viol;
  logic [31:0] first_word, last_word, prev_data;
  bit          prev_hold = 0;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int mode, input int idx);
    logic [7:0] b;
    b = 8'(idx / 8);
    case (mode)
      0:       return !idx[0];
      1:       return 1'b1;
      default: return b[idx % 8];
    endcase
  endfunction

  // Phase counter, scan_out driver and bit-level reference model.
  initial begin
    clk_counter = '0;
    scan_out    = 1'b0;
    exp_acc     = '0;
    forever begin
      @(posedge clk);
      if (run_armed) begin
        if (shift_phase && clk_counter == test_sample_phase && samp_idx < run_max) begin
          exp_acc[samp_idx % 32] = pat_bit(pat_mode, samp_idx);
          if ((samp_idx % 32) == 31 || samp_idx == run_max - 1) begin
            sb_q.push_back(exp_acc);
            exp_acc = '0;
          end
          samp_idx++;
        end
        if (clk_counter == test_delay) begin
          ticks++;
          if (ticks == 2) shift_phase = 1;
        end
      end
      #1;
      clk_counter = 6'((int'(clk_counter) + 1) % PERIOD);
      scan_out    = pat_bit(pat_mode, samp_idx);
    end
  end

  // Output monitor: scoreboard pops, scan_load window, data stability.
  initial begin
    forever begin
      @(negedge clk);
      if (word_if.word_valid) valid_seen++;
      if (run_armed && (o_scan_load !== !(shift_phase && samp_idx < run_max))) load_viol++;
      if (prev_hold && word_if.word_valid && word_if.word_data !== prev_data) stab_viol++;
      prev_hold = word_if.word_valid && !word_if.word_ready;
      prev_data = word_if.word_data;
      if (word_if.word_valid && word_if.word_ready) begin
        n_pop++;
        if (n_pop == 1) first_word = word_if.word_data;
        last_word = word_if.word_data;
        if (sb_q.size() == 0) n_extra++;
        else check("sb_word", word_if.word_data, sb_q.pop_front());
      end
    end
  end

  task automatic start_run();
    do @(negedge clk); while (clk_counter == test_delay);
    sb_q.delete();
    exp_acc = '0; samp_idx = 0; ticks = 0; shift_phase = 0; run_armed = 1;
    n_pop = 0; n_extra = 0; valid_seen = 0; load_viol = 0; stab_viol = 0;
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    test_delay         = 6'd2;
    test_sample_phase  = 6'((2 + v.off) % PERIOD);
    scan_cnt_max       = CNT_W'(v.max);
    pat_mode           = v.mode;
    run_max            = v.max;
    word_if.word_ready = v.ready;
  endtask

  task automatic run_vec(input vec_t v);
    int budget;
    setup(v);
    start_run();
    budget = v.max * PERIOD + 8 * PERIOD;
    while (!status_done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({v.name, "_done"}, status_done, 1);
    repeat (4) @(negedge clk);
    check({v.name, "_bitcnt"}, bit_cnt, v.max);
    check({v.name, "_idle"}, {state, o_scan_load}, {3'd0, 1'b1});
    check({v.name, "_ovf"}, status_overflow, v.ovf);
    check({v.name, "_load_window"}, load_viol, 0);
    check({v.name, "_extra"}, n_extra, 0);
    if (v.ready) begin
      check({v.name, "_words"}, n_pop, v.words);
      check({v.name, "_sb_left"}, sb_q.size(), 0);
      if (v.words > 0) begin
        check({v.name, "_w0"}, first_word, v.w0);
        check({v.name, "_wlast"}, last_word, v.wlast);
      end else begin
        check({v.name, "_valid_seen"}, valid_seen, 0);
      end
    end else begin
      check({v.name, "_words"}, n_pop, 0);
      check({v.name, "_held_valid"}, word_if.word_valid, 1);
      check({v.name, "_held_data"}, word_if.word_data, v.w0);
      check({v.name, "_held_model"}, word_if.word_data, sb_q[0]);
      check({v.name, "_stable"}, stab_viol, 0);
      word_if.word_ready = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    int budget;
    reset = 1'b1; enable = 1'b1; start_re = 1'b0;
    word_if.word_ready = 1'b1;
    test_delay = 6'd2; test_sample_phase = 6'd5; scan_cnt_max = '0;

    vecs[0] = '{"nominal",   768, 0, 1'b1, 3, 24, 32'h55555555, 32'h55555555, 1'b0};
    vecs[1] = '{"partial",    40, 1, 1'b1, 3,  2, 32'hFFFFFFFF, 32'h000000FF, 1'b0};
    vecs[2] = '{"backpress", 768, 0, 1'b0, 3, 24, 32'h55555555, 32'h55555555, 1'b1};
    vecs[3] = '{"zero_bits",   0, 1, 1'b1, 3,  0, 32'h0,        32'h0,        1'b0};
    vecs[4] = '{"ramp_ph0",  768, 2, 1'b1, 0, 24, 32'h03020100, 32'h5F5E5D5C, 1'b0};
    vecs[5] = '{"ramp_ph5",  768, 2, 1'b1, 5, 24, 32'h03020100, 32'h5F5E5D5C, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_state",
          {state, o_scan_load, word_if.word_valid, word_if.word_data, bit_cnt, status_done, status_overflow},
          {3'd0, 1'b1, 1'b0, 32'h0, 11'h0, 1'b0, 1'b0});
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Async reset in the middle of SHIFT, then a clean full run.
    setup(vecs[0]);
    start_run();
    budget = 120 * PERIOD;
    while (samp_idx < 100 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_bitcnt", bit_cnt, 100);
    run_armed = 0;
    #1 reset = 1'b1;
    #1;
    check("async_reset",
          {state, o_scan_load, word_if.word_valid, word_if.word_data, bit_cnt, status_done, status_overflow},
          {3'd0, 1'b1, 1'b0, 32'h0, 11'h0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);

    // enable low mid-run acts as a synchronous clear.
    setup(vecs[1]);
    start_run();
    budget = 8 * PERIOD;
    while (samp_idx < 5 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    run_armed = 0;
    enable = 1'b0;
    @(negedge clk);
    check("enable_clear", {state, o_scan_load, word_if.word_valid, bit_cnt}, {3'd0, 1'b1, 1'b0, 11'h0});
    enable = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
